rom_sequencer: RTL and testbench

Controller for the 4-word × 4-bit lookup ROM that drives LED[7:4] on the lab board. Replaces the raw switch-to-address path with a sequencer that fetches ROM words manually, by auto-scan up or down, or by single-step, and reports the current address, data, a wrap pulse and a completed-pass count. Sits between the SWI inputs and the LED/LCD outputs in `top`, clocked by `clk_2`.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/seq_rom.sv | 20 ++
 rtl/rom_sequencer.sv | 174 +++++++++++++++++
 tb/tb_rom_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types and ROM image for the LED ROM sequencer.
// Revision : 1.0
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MANUAL    = 2'b00,
        AUTO_UP   = 2'b01,
        AUTO_DOWN = 2'b10,
        STEP      = 2'b11
    } mode_t;

    // Word [0] sits in the least-significant nibble.
    localparam logic [3:0][3:0] c_rom_data = {4'hC, 4'h9, 4'h2, 4'h3};

    function automatic logic [1:0] f_addr_step(input logic [1:0] addr, input logic up);
        return up ? addr + 2'd1 : addr - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_rom.sv
`default_nettype none
// ============================================================================
// Module   : seq_rom
// Brief    : 4-word x 4-bit ROM with a registered read (latency 1).
// Revision : 1.0
// ============================================================================
module seq_rom
    import seq_pkg::*;
(
    input  logic       clk_2,
    input  logic [1:0] addr,
    output logic [3:0] data
);

    always_ff @(posedge clk_2) begin
        data <= c_rom_data[addr];
    end

endmodule
`default_nettype wire

// File: rtl/rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_sequencer
// Brief    : Fetches ROM words manually, by up/down auto-scan or single-step;
//            reports address, data, wrap pulse and saturating pass count.
//            Optional HOLD-cycle prescaler enabled by SEQ_PRESCALE_EN.
// Revision : 1.0
// ============================================================================
module rom_sequencer
    import seq_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic [1:0]       man_addr,
    input  logic             step,
    input  logic             hold,
    output logic [1:0]       addr_out,
    output logic [3:0]       data_out,
    output logic             valid,
    output logic             wrap,
    output logic [CNT_W-1:0] pass_count
);

    state_t           r_state;
    logic [1:0]       r_addr;
    logic [3:0]       r_data;
    logic             r_valid;
    logic             r_wrap;
    logic [CNT_W-1:0] r_count;
    logic             r_step_q;
    logic             r_step_pend;

    mode_t            w_mode;
    logic             w_tick;
    logic             w_adv;
    logic             w_wrap;
    logic             w_consume;
    logic [1:0]       w_next;
    logic [1:0]       w_rom_addr;
    logic [3:0]       w_rom_data;
    logic             w_step_rise;

    assign w_mode      = mode_t'(mode);
    assign w_step_rise = step & ~r_step_q;

`ifdef SEQ_PRESCALE_EN
    localparam int               c_pre_w   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);

    logic [c_pre_w-1:0] r_pre;
    mode_t              r_mode_q;
    logic               w_auto;

    assign w_auto = (w_mode == AUTO_UP) || (w_mode == AUTO_DOWN);
    assign w_tick = (r_pre == c_pre_max);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_pre    <= '0;
            r_mode_q <= MANUAL;
        end else begin
            r_mode_q <= w_mode;
            if (w_mode != r_mode_q) begin
                r_pre <= '0;
            end else if (r_state == HOLD && !hold && w_auto) begin
                r_pre <= w_tick ? '0 : r_pre + c_pre_w'(1);
            end
        end
    end
`else
    logic [31:0] w_unused_prescale;

    assign w_unused_prescale = PRESCALE;
    assign w_tick            = 1'b1;
`endif

    always_comb begin
        w_adv     = 1'b0;
        w_wrap    = 1'b0;
        w_consume = 1'b0;
        w_next    = r_addr;
        if (r_state == HOLD && !hold) begin
            case (w_mode)
                MANUAL: begin
                    w_adv  = (man_addr != r_addr);
                    w_next = man_addr;
                end
                AUTO_UP: begin
                    w_adv  = w_tick;
                    w_next = f_addr_step(r_addr, 1'b1);
                    w_wrap = (r_addr == 2'd3);
                end
                AUTO_DOWN: begin
                    w_adv  = w_tick;
                    w_next = f_addr_step(r_addr, 1'b0);
                    w_wrap = (r_addr == 2'd0);
                end
                default: begin
                    w_adv     = r_step_pend;
                    w_consume = r_step_pend;
                    w_next    = f_addr_step(r_addr, 1'b1);
                    w_wrap    = (r_addr == 2'd3);
                end
            endcase
        end
    end

    // The ROM is fed the address being loaded so its word is ready during READ.
    always_comb begin
        w_rom_addr = r_addr;
        if (r_state == IDLE) begin
            w_rom_addr = 2'd0;
        end else if (w_adv) begin
            w_rom_addr = w_next;
        end
    end

    seq_rom u_rom (
        .clk_2 (clk_2),
        .addr  (w_rom_addr),
        .data  (w_rom_data)
    );

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_addr      <= 2'd0;
            r_data      <= 4'd0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_count     <= '0;
            r_step_q    <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            r_step_q    <= step;
            r_step_pend <= w_consume ? 1'b0 : (r_step_pend | w_step_rise);
            r_wrap      <= w_adv & w_wrap;
            if (w_adv && w_wrap && !(&r_count)) begin
                r_count <= r_count + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    r_addr  <= 2'd0;
                    r_state <= READ;
                end
                READ: begin
                    r_data  <= w_rom_data;
                    r_valid <= 1'b1;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (w_adv) begin
                        r_addr  <= w_next;
                        r_valid <= 1'b0;
                        r_state <= READ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign addr_out   = r_addr;
    assign data_out   = r_data;
    assign valid      = r_valid;
    assign wrap       = r_wrap;
    assign pass_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_sequencer
// Brief    : Self-checking bench for rom_sequencer (default build).
// Revision : 1.0
// ============================================================================
module tb_rom_sequencer;

    logic       clk_2   = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] mode    = 2'd0;
    logic [1:0] man_addr = 2'd0;
    logic       step    = 1'b0;
    logic       hold    = 1'b0;

    logic [1:0] addr_out;
    logic [3:0] data_out;
    logic       valid;
    logic       wrap;
    logic [7:0] pass_count;

    rom_sequencer #(.PRESCALE(4), .CNT_W(8)) dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .mode       (mode),
        .man_addr   (man_addr),
        .step       (step),
        .hold       (hold),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .valid      (valid),
        .wrap       (wrap),
        .pass_count (pass_count)
    );

    always #5 clk_2 = ~clk_2;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: word shown, fetch pending, and rules for advancing.
    int rom [4] = '{3, 2, 9, 12};
    int m_phase = 0;   // 0 = not started, 1 = fetching, 2 = showing
    int m_addr  = 0;
    int m_data  = 0;
    int m_cnt   = 0;
    int m_nxt;
    bit m_valid = 0, m_wrap = 0, m_pend = 0, m_stepq = 0;
    bit m_rise, m_adv, m_use;

    always @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_addr = 0; m_data = 0; m_cnt = 0;
            m_valid = 0; m_wrap = 0; m_pend = 0; m_stepq = 0;
        end else begin
            m_rise  = step && !m_stepq;
            m_stepq = step;
            m_adv   = 0;
            m_use   = 0;
            m_wrap  = 0;
            m_nxt   = m_addr;
            if (m_phase == 0) begin
                m_phase = 1;
                m_addr  = 0;
            end else if (m_phase == 1) begin
                m_data  = rom[m_addr];
                m_valid = 1;
                m_phase = 2;
            end else if (!hold) begin
                case (mode)
                    2'd0: begin m_adv = (int'(man_addr) != m_addr); m_nxt = man_addr; end
                    2'd1: begin m_adv = 1; m_nxt = (m_addr + 1) % 4; end
                    2'd2: begin m_adv = 1; m_nxt = (m_addr + 3) % 4; end
                    default: begin m_adv = m_pend; m_use = m_pend; m_nxt = (m_addr + 1) % 4; end
                endcase
                if (m_adv) begin
                    m_wrap = (mode != 2'd0) &&
                             ((m_addr == 3 && m_nxt == 0) || (m_addr == 0 && m_nxt == 3));
                    if (m_wrap && m_cnt < 255) m_cnt++;
                    m_addr  = m_nxt;
                    m_valid = 0;
                    m_phase = 1;
                end
            end
            if (m_use) m_pend = 0;
            else if (m_rise) m_pend = 1;
        end
    end

    always @(negedge clk_2) begin
        chk("addr_out", int'(addr_out), m_addr);
        chk("data_out", int'(data_out), m_data);
        chk("valid", int'(valid), int'(m_valid));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("pass_count", int'(pass_count), m_cnt);
    end

    int exp_data [4] = '{3, 2, 9, 12};

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk_2);
        chk("rst_addr", int'(addr_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_count", int'(pass_count), 0);

        // Auto-up scan, one word per two cycles, wraps once.
        mode = 2'd1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (2) @(negedge clk_2);
            chk("up_addr", int'(addr_out), k);
            chk("up_data", int'(data_out), exp_data[k]);
            chk("up_valid", int'(valid), 1);
        end
        @(negedge clk_2);
        chk("up_wrap", int'(wrap), 1);
        chk("up_wrap_addr", int'(addr_out), 0);
        chk("up_count", int'(pass_count), 1);
        @(negedge clk_2);
        chk("up_again_data", int'(data_out), 3);
        chk("up_wrap_off", int'(wrap), 0);

        // Auto-down from address 0 wraps to 3.
        mode = 2'd2;
        @(negedge clk_2);
        chk("dn_addr", int'(addr_out), 3);
        chk("dn_wrap", int'(wrap), 1);
        chk("dn_count", int'(pass_count), 2);
        @(negedge clk_2);
        chk("dn_data", int'(data_out), 12);

        // Manual jump, then stay put.
        mode = 2'd0;
        man_addr = 2'd2;
        repeat (2) @(negedge clk_2);
        chk("man_addr", int'(addr_out), 2);
        chk("man_data", int'(data_out), 9);
        chk("man_valid", int'(valid), 1);
        repeat (4) @(negedge clk_2);
        chk("man_stay", int'(addr_out), 2);
        man_addr = 2'd0;
        repeat (2) @(negedge clk_2);
        chk("man_no_wrap_count", int'(pass_count), 2);

        // Single-step: three spaced pulses.
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            @(negedge clk_2);
            step = 1'b0;
            repeat (4) @(negedge clk_2);
            chk("step_addr", int'(addr_out), i + 1);
        end

        // Two edges while a request is pending give one advance.
        hold = 1'b1;
        step = 1'b1; @(negedge clk_2);
        step = 1'b0; @(negedge clk_2);
        step = 1'b1; @(negedge clk_2);
        step = 1'b0; @(negedge clk_2);
        chk("step_held_addr", int'(addr_out), 3);
        hold = 1'b0;
        repeat (6) @(negedge clk_2);
        chk("step_once_addr", int'(addr_out), 0);
        chk("step_wrap_count", int'(pass_count), 3);

        // Auto-up frozen by hold.
        mode = 2'd1;
        hold = 1'b1;
        repeat (10) begin
            @(negedge clk_2);
            chk("hold_addr", int'(addr_out), 0);
        end
        hold = 1'b0;
        @(negedge clk_2);
        chk("hold_resume", int'(addr_out), 1);
        @(negedge clk_2);
        mode = 2'd0;
        man_addr = 2'd2;
        @(negedge clk_2);
        chk("pre_rst_addr", int'(addr_out), 2);

        // Asynchronous reset in READ at address 2.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_addr", int'(addr_out), 0);
        chk("arst_data", int'(data_out), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_count", int'(pass_count), 0);
        repeat (2) @(negedge clk_2);
        mode = 2'd1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk_2);
        chk("restart_addr", int'(addr_out), 0);
        chk("restart_data", int'(data_out), 3);

        // Saturation after more than 255 wraps.
        repeat (256 * 8 + 8) @(negedge clk_2);
        chk("sat_count", int'(pass_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
